// File: rtl/mem_access_unit.sv
// Memory access unit: combinational store formatter plus a registered load formatter.
// Optional feature macro: MEM_IO_READ_EN (IO-region loads return io_data_in when defined).
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] address,
  input  logic        stall,
  input  logic [31:0] data_in,
  input  logic [31:0] dmem_data_in,
  input  logic [31:0] bios_data_in,
  input  logic [31:0] io_data_in,
  output logic [31:0] data_out,
  output logic [3:0]  write_enable_mask,
  output logic        dmem_write_enable,
  output logic        imem_write_enable,
  output logic [31:0] load_data_out
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] RGN_DMEM    = 4'b0001;
  localparam logic [3:0] RGN_IMEM    = 4'b0010;
  localparam logic [3:0] RGN_SHARED  = 4'b0011;
  localparam logic [3:0] RGN_BIOS    = 4'b0100;
  localparam logic [3:0] RGN_IO      = 4'b1000;

  logic [6:0] opcode_p0;
  logic [2:0] funct3_p0;
  logic [3:0] region_p0;
  logic       store_ok_p0;

  assign opcode_p0 = instruction[6:0];
  assign funct3_p0 = instruction[14:12];
  assign region_p0 = address[31:28];

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sign_en);
    logic signed [7:0] sb;
    sb = signed'(b);
    extend_byte = sign_en ? {{24{sb[7]}}, b} : {24'b0, b};
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sign_en);
    logic signed [15:0] sh;
    sh = signed'(h);
    extend_half = sign_en ? {{16{sh[15]}}, h} : {16'b0, h};
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    case (off)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_W:    format_load = word;
      F3_H:    format_load = extend_half(sel_half, 1'b1);
      F3_HU:   format_load = extend_half(sel_half, 1'b0);
      F3_B:    format_load = extend_byte(sel_byte, 1'b1);
      F3_BU:   format_load = extend_byte(sel_byte, 1'b0);
      default: format_load = 32'b0;
    endcase
  endfunction

  // Stage p0: store formatting straight from the current inputs
  always_comb begin
    data_out          = data_in;
    write_enable_mask = 4'b0000;
    store_ok_p0       = 1'b0;
    if (opcode_p0 == OPC_STORE) begin
      case (funct3_p0)
        F3_W: begin
          write_enable_mask = 4'b1111;
          store_ok_p0       = 1'b1;
        end
        F3_H: begin
          data_out          = {2{data_in[15:0]}};
          write_enable_mask = address[1] ? 4'b1100 : 4'b0011;
          store_ok_p0       = 1'b1;
        end
        F3_B: begin
          data_out          = {4{data_in[7:0]}};
          write_enable_mask = 4'b0001 << address[1:0];
          store_ok_p0       = 1'b1;
        end
        default: begin
          write_enable_mask = 4'b0000;
          store_ok_p0       = 1'b0;
        end
      endcase
    end
  end

  assign dmem_write_enable = store_ok_p0 &&
                             ((region_p0 == RGN_DMEM) || (region_p0 == RGN_SHARED));
  assign imem_write_enable = store_ok_p0 &&
                             ((region_p0 == RGN_IMEM) || (region_p0 == RGN_SHARED));

  // Stage p0 -> p1: load context, aligned with the synchronous memory read latency
  logic       vld_p1;
  logic [2:0] funct3_p1;
  logic [3:0] region_p1;
  logic [1:0] offset_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      funct3_p1 <= 3'b000;
      region_p1 <= 4'b0000;
      offset_p1 <= 2'b00;
    end else if (!stall) begin
      vld_p1    <= (opcode_p0 == OPC_LOAD);
      funct3_p1 <= funct3_p0;
      region_p1 <= region_p0;
      offset_p1 <= address[1:0];
    end
  end

  // Stage p1: pick the responding memory and format the result
  logic [31:0] rd_word_p1;

  always_comb begin
    rd_word_p1 = 32'b0;
    case (region_p1)
      RGN_DMEM, RGN_SHARED: rd_word_p1 = dmem_data_in;
      RGN_BIOS:             rd_word_p1 = bios_data_in;
`ifdef MEM_IO_READ_EN
      RGN_IO:               rd_word_p1 = io_data_in;
`endif
      default:              rd_word_p1 = 32'b0;
    endcase
  end

  assign load_data_out = vld_p1 ? format_load(funct3_p1, offset_p1, rd_word_p1) : 32'b0;

`ifdef MEM_IO_READ_EN
  logic unused_bits;
  assign unused_bits = ^{instruction[31:15], instruction[11:7], address[27:2]};
`else
  logic unused_bits;
  assign unused_bits = ^{instruction[31:15], instruction[11:7], address[27:2],
                         io_data_in, RGN_IO};
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed store/load steps with a
// scoreboard queue of expected results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] address;
  logic        stall;
  logic [31:0] data_in;
  logic [31:0] dmem_data_in;
  logic [31:0] bios_data_in;
  logic [31:0] io_data_in;
  logic [31:0] data_out;
  logic [3:0]  write_enable_mask;
  logic        dmem_write_enable;
  logic        imem_write_enable;
  logic [31:0] load_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ALU   = 7'b0010011;

  mem_access_unit dut (
    .clk               (clk),
    .rst               (rst),
    .instruction       (instruction),
    .address           (address),
    .stall             (stall),
    .data_in           (data_in),
    .dmem_data_in      (dmem_data_in),
    .bios_data_in      (bios_data_in),
    .io_data_in        (io_data_in),
    .data_out          (data_out),
    .write_enable_mask (write_enable_mask),
    .dmem_write_enable (dmem_write_enable),
    .imem_write_enable (imem_write_enable),
    .load_data_out     (load_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    mk = {17'b0, f3, 5'b0, opc};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected packing for stores: {data_out, mask, dmem_we, imem_we}
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] d, input logic [31:0] e_data,
                          input logic [3:0] e_mask, input logic e_dwe,
                          input logic e_iwe, input string tag);
    instruction = mk(OPC_STORE, f3);
    address     = addr;
    data_in     = d;
    exp_q.push_back({26'b0, e_data, e_mask, e_dwe, e_iwe});
    #1;
    check(tag, {26'b0, data_out, write_enable_mask, dmem_write_enable, imem_write_enable},
          exp_q.pop_front());
  endtask

  // Presents a load, advances one clock, then supplies the memory read data
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] dmem, input logic [31:0] bios,
                         input logic [31:0] io, input logic [31:0] e_val,
                         input string tag);
    instruction = mk(OPC_LOAD, f3);
    address     = addr;
    exp_q.push_back({32'b0, e_val});
    @(posedge clk);
    #1;
    instruction  = mk(OPC_ALU, 3'b000);
    address      = 32'h0;
    dmem_data_in = dmem;
    bios_data_in = bios;
    io_data_in   = io;
    #1;
    check(tag, {32'b0, load_data_out}, exp_q.pop_front());
  endtask

  initial begin
    rst          = 1'b1;
    instruction  = 32'h0;
    address      = 32'h0;
    stall        = 1'b0;
    data_in      = 32'h0;
    dmem_data_in = 32'h0;
    bios_data_in = 32'h0;
    io_data_in   = 32'h0;
    #3;
    dmem_data_in = 32'hAABBCCDD;
    #1;
    check("reset_load_zero", {32'b0, load_data_out}, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Non-store passes data through with no enables
    instruction = mk(OPC_ALU, 3'b010);
    address     = 32'h10000000;
    data_in     = 32'h12345678;
    #1;
    check("nonstore", {26'b0, data_out, write_enable_mask, dmem_write_enable, imem_write_enable},
          {26'b0, 32'h12345678, 4'b0000, 1'b0, 1'b0});

    do_store(3'b010, 32'h20000000, 32'hABABABAB, 32'hABABABAB, 4'b1111, 1'b0, 1'b1, "sw_imem");
    do_store(3'b010, 32'h30000004, 32'h01234567, 32'h01234567, 4'b1111, 1'b1, 1'b1, "sw_shared");
    do_store(3'b001, 32'h10000000, 32'h0000ABAB, 32'hABABABAB, 4'b0011, 1'b1, 1'b0, "sh_a0");
    do_store(3'b001, 32'h10000001, 32'h0000ABAB, 32'hABABABAB, 4'b0011, 1'b1, 1'b0, "sh_a1");
    do_store(3'b001, 32'h10000002, 32'hFFFF1234, 32'h12341234, 4'b1100, 1'b1, 1'b0, "sh_a2");
    do_store(3'b000, 32'h10000000, 32'h000000AB, 32'hABABABAB, 4'b0001, 1'b1, 1'b0, "sb_a0");
    do_store(3'b000, 32'h10000002, 32'h000000AB, 32'hABABABAB, 4'b0100, 1'b1, 1'b0, "sb_a2");
    do_store(3'b000, 32'h20000003, 32'h000000AB, 32'hABABABAB, 4'b1000, 1'b0, 1'b1, "sb_a3_imem");
    do_store(3'b000, 32'h40000001, 32'h0000005A, 32'h5A5A5A5A, 4'b0010, 1'b0, 1'b0, "sb_bios_noen");
    do_store(3'b011, 32'h10000000, 32'hCAFEF00D, 32'hCAFEF00D, 4'b0000, 1'b0, 1'b0, "store_bad_f3");

    do_load(3'b010, 32'h10000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hAABBCCDD, "lw_dmem");
    do_load(3'b010, 32'h40000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h11223344, "lw_bios");
    do_load(3'b010, 32'h10000003, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hAABBCCDD, "lw_a3");
    do_load(3'b010, 32'h30000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hAABBCCDD, "lw_shared");
    do_load(3'b001, 32'h10000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hFFFFCCDD, "lh_a0");
    do_load(3'b001, 32'h10000001, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hFFFFCCDD, "lh_a1");
    do_load(3'b001, 32'h40000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00003344, "lh_bios0");
    do_load(3'b001, 32'h40000001, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00003344, "lh_bios1");
    do_load(3'b001, 32'h10000002, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hFFFFAABB, "lh_a2");
    do_load(3'b101, 32'h10000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h0000CCDD, "lhu_a0");
    do_load(3'b000, 32'h10000001, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hFFFFFFCC, "lb_a1");
    do_load(3'b000, 32'h40000001, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00000033, "lb_bios1");
    do_load(3'b000, 32'h10000003, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hFFFFFFAA, "lb_a3");
    do_load(3'b000, 32'h40000003, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00000011, "lb_bios3");
    do_load(3'b000, 32'h10000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hFFFFFFDD, "lb_a0");
    do_load(3'b100, 32'h10000002, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h000000BB, "lbu_a2");
    do_load(3'b011, 32'h10000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00000000, "load_bad_f3");
    do_load(3'b010, 32'h20000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00000000, "lw_imem_rgn");
`ifdef MEM_IO_READ_EN
    do_load(3'b010, 32'h80000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h55667788, "lw_io");
    do_load(3'b000, 32'h80000002, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00000066, "lb_io");
`else
    do_load(3'b010, 32'h80000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00000000, "lw_io_off");
`endif

    // Store in the cycle after a load leaves the load result intact
    do_load(3'b010, 32'h10000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'hAABBCCDD, "lw_before_sw");
    do_store(3'b010, 32'h10000008, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, "sw_after_lw");
    exp_q.push_back({32'b0, 32'hAABBCCDD});
    check("load_during_store", {32'b0, load_data_out}, exp_q.pop_front());

    // Stall holds the load context while the instruction changes
    instruction = mk(OPC_ALU, 3'b000);
    stall = 1'b1;
    exp_q.push_back({32'b0, 32'hAABBCCDD});
    @(posedge clk);
    #1;
    check("stall_hold", {32'b0, load_data_out}, exp_q.pop_front());
    dmem_data_in = 32'h12345678;
    exp_q.push_back({32'b0, 32'h12345678});
    #1;
    check("stall_new_mem_data", {32'b0, load_data_out}, exp_q.pop_front());
    stall = 1'b0;
    exp_q.push_back({32'b0, 32'h0});
    @(posedge clk);
    #1;
    check("unstall_capture_alu", {32'b0, load_data_out}, exp_q.pop_front());

    // Asynchronous reset clears the load result mid-cycle
    do_load(3'b010, 32'h40000000, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h11223344, "lw_before_rst");
    #2;
    rst = 1'b1;
    exp_q.push_back({32'b0, 32'h0});
    #1;
    check("async_rst_zero", {32'b0, load_data_out}, exp_q.pop_front());
    instruction = mk(OPC_STORE, 3'b010);
    address     = 32'h10000000;
    data_in     = 32'h0BADF00D;
    #1;
    check("store_during_rst",
          {26'b0, data_out, write_enable_mask, dmem_write_enable, imem_write_enable},
          {26'b0, 32'h0BADF00D, 4'b1111, 1'b1, 1'b0});
    instruction = mk(OPC_LOAD, 3'b010);
    @(posedge clk);
    #1;
    check("rst_held_zero", {32'b0, load_data_out}, 64'h0);
    rst = 1'b0;
    instruction = mk(OPC_ALU, 3'b000);
    do_load(3'b000, 32'h40000003, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h00000011, "lb_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
